// File: rtl/seq_scan_ctrl_if.sv
// rtl/seq_scan_ctrl_if.sv - producer handshake and detector link bundle for seq_scan_ctrl
interface seq_scan_ctrl_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5,
    parameter int POS_W = 4
);
    logic             start;
    logic [WIDTH-1:0] data_in;
    logic             abort;
    logic             busy;
    logic             done;
    logic             aborted;
    logic [CNT_W-1:0] match_count;
    logic             first_valid;
    logic [POS_W-1:0] first_pos;
    logic             det_w;
    logic             det_rst_n;
    logic             det_z;

    // Producer / detector side
    modport master (
        output start, data_in, abort, det_z,
        input  busy, done, aborted, match_count, first_valid, first_pos, det_w, det_rst_n
    );

    // Controller side
    modport slave (
        input  start, data_in, abort, det_z,
        output busy, done, aborted, match_count, first_valid, first_pos, det_w, det_rst_n
    );
endinterface

// File: rtl/seq_scan_ctrl.sv
// rtl/seq_scan_ctrl.sv - sequences a serial Mealy detector over a parallel word
module seq_scan_ctrl #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5,
    parameter int POS_W = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    seq_scan_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] shift_reg;
    logic [POS_W-1:0] idx;
    logic [CNT_W-1:0] match_count;
    logic             first_valid;
    logic [POS_W-1:0] first_pos;
    logic             aborted;
    logic             busy;
    logic             done;
    logic             det_w;
    logic             det_clr;
    logic             last_bit;

    assign last_bit = (idx == POS_W'(WIDTH - 1));

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next state and registered-state output decode
    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        det_w     = 1'b0;
        det_clr   = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (bus.start) state_nxt = CLEAR;
            end
            CLEAR: begin
                det_clr   = 1'b1;
                state_nxt = bus.abort ? DONE : SHIFT;
            end
            SHIFT: begin
                det_w = shift_reg[WIDTH-1];
                if (bus.abort || last_bit) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Word shifting, detector sampling and result capture
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_reg   <= '0;
            idx         <= '0;
            match_count <= '0;
            first_valid <= 1'b0;
            first_pos   <= '0;
            aborted     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        shift_reg   <= bus.data_in;
                        idx         <= '0;
                        match_count <= '0;
                        first_valid <= 1'b0;
                        first_pos   <= '0;
                        aborted     <= 1'b0;
                    end
                end
                CLEAR: begin
                    if (bus.abort) aborted <= 1'b1;
                end
                SHIFT: begin
                    // The detector is Mealy, so z belongs to the bit presented this cycle.
                    if (bus.det_z) begin
                        if (match_count != '1) match_count <= match_count + CNT_W'(1);
                        if (!first_valid) begin
                            first_valid <= 1'b1;
                            first_pos   <= idx;
                        end
                    end
                    shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
                    idx       <= idx + POS_W'(1);
                    if (bus.abort) aborted <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Detector reset follows the controller reset and pulses low in CLEAR
    assign bus.det_rst_n   = reset_n & ~det_clr;
    assign bus.det_w       = det_w;
    assign bus.busy        = busy;
    assign bus.done        = done;
    assign bus.aborted     = aborted;
    assign bus.match_count = match_count;
    assign bus.first_valid = first_valid;
    assign bus.first_pos   = first_pos;
endmodule

// File: tb/tb_seq_scan_ctrl.sv
// tb/tb_seq_scan_ctrl.sv - randomized and directed bench for seq_scan_ctrl against a word-level model
module tb_seq_scan_ctrl;
    localparam int W = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  data_in = '0;
    logic          abort = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    seq_scan_ctrl_if #(.WIDTH(W), .CNT_W(5), .POS_W(4)) ia ();
    seq_scan_ctrl_if #(.WIDTH(W), .CNT_W(2), .POS_W(4)) ib ();

    seq_scan_ctrl #(.WIDTH(W), .CNT_W(5), .POS_W(4)) dut_a (.clk(clk), .reset_n(reset_n), .bus(ia));
    seq_scan_ctrl #(.WIDTH(W), .CNT_W(2), .POS_W(4)) dut_b (.clk(clk), .reset_n(reset_n), .bus(ib));

    always #5 clk = ~clk;

    assign ia.start = start;  assign ia.data_in = data_in;  assign ia.abort = abort;
    assign ib.start = start;  assign ib.data_in = data_in;  assign ib.abort = abort;

    // Overlapping 1101 Mealy detectors: remember the last three bits seen
    logic [2:0] ha = '0;
    logic [2:0] hb = '0;
    always @(posedge clk or negedge ia.det_rst_n)
        if (!ia.det_rst_n) ha <= '0; else ha <= {ha[1:0], ia.det_w};
    always @(posedge clk or negedge ib.det_rst_n)
        if (!ib.det_rst_n) hb <= '0; else hb <= {hb[1:0], ib.det_w};
    assign ia.det_z = ia.det_rst_n & (ha == 3'b110) & ia.det_w;
    assign ib.det_z = ib.det_rst_n & (hb == 3'b110) & ib.det_w;

    // Number of 1101 windows ending at bit indices below n (index 0 = MSB)
    function automatic int cnt_upto(input logic [W-1:0] w, input int n);
        int c = 0;
        for (int i = 3; i < n; i++)
            if (((w >> (W - 1 - i)) & 16'hF) == 16'hD) c++;
        return c;
    endfunction

    function automatic int first_at(input logic [W-1:0] w, input int n);
        for (int i = 3; i < n; i++)
            if (((w >> (W - 1 - i)) & 16'hF) == 16'hD) return i;
        return -1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Timeline model: mcyc = cycle number since the accepting edge (0 idle, 18 done)
    int           mcyc = 0;
    int           mn = 0;
    logic [W-1:0] mword = '0;
    logic         mab = 1'b0;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mcyc <= 0; mn <= 0; mword <= '0; mab <= 1'b0;
        end else if (mcyc == 0) begin
            if (start) begin mcyc <= 1; mword <= data_in; mn <= 0; mab <= 1'b0; end
        end else if (mcyc == 1) begin
            if (abort) begin mcyc <= W + 2; mab <= 1'b1; end
            else mcyc <= 2;
        end else if (mcyc <= W + 1) begin
            mn <= mn + 1;
            if (abort) mab <= 1'b1;
            mcyc <= (abort || mcyc == W + 1) ? W + 2 : mcyc + 1;
        end else begin
            mcyc <= 0;
        end
    end

    // Every-cycle comparison of both instances against the model
    always @(negedge clk) begin : cmp
        int c, fp;
        logic ew;
        c  = cnt_upto(mword, mn);
        fp = first_at(mword, mn);
        ew = (mcyc >= 2 && mcyc <= W + 1) ? mword[W + 1 - mcyc] : 1'b0;
        chk("busy_a", ia.busy, mcyc != 0);
        chk("done_a", ia.done, mcyc == W + 2);
        chk("det_w_a", ia.det_w, ew);
        chk("det_rst_n_a", ia.det_rst_n, reset_n && mcyc != 1);
        chk("aborted_a", ia.aborted, mab);
        chk("count_a", ia.match_count, (c > 31) ? 31 : c);
        chk("fvalid_a", ia.first_valid, fp >= 0);
        chk("fpos_a", ia.first_pos, (fp < 0) ? 0 : fp);
        chk("busy_b", ib.busy, mcyc != 0);
        chk("done_b", ib.done, mcyc == W + 2);
        chk("det_w_b", ib.det_w, ew);
        chk("count_b", ib.match_count, (c > 3) ? 3 : c);
        chk("fpos_b", ib.first_pos, (fp < 0) ? 0 : fp);
    end

    int done_cnt, done_cyc, busy_cnt, rstlow_cnt, rstlow_cyc;
    logic [W-1:0] wstream;

    // One scan: called at #1 after an edge while idle; events numbered by cycle since accept
    task automatic scan(input logic [W-1:0] w, input int abort_c, input int start_c, input int rst_c);
        done_cnt = 0; done_cyc = -1; busy_cnt = 0; rstlow_cnt = 0; rstlow_cyc = -1; wstream = '0;
        start = 1'b1; data_in = w; abort = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            abort = (c == abort_c);
            start = (c == start_c);
            data_in = W'($urandom);
            if (c == rst_c) begin
                abort = 1'b0; start = 1'b0;
                reset_n = 1'b0;
                repeat (2) begin
                    @(negedge clk);
                    if (ia.done) done_cnt++;
                    @(posedge clk);
                end
                #1 reset_n = 1'b1;
                break;
            end
            @(negedge clk);
            if (ia.done) begin done_cnt++; done_cyc = c; end
            if (ia.busy) busy_cnt++;
            if (!ia.det_rst_n) begin rstlow_cnt++; rstlow_cyc = c; end
            if (c >= 2 && c <= W + 1) wstream = {wstream[W-2:0], ia.det_w};
            @(posedge clk); #1;
        end
        abort = 1'b0; start = 1'b0;
    endtask

    initial begin
        // Model pins
        chk("model_d000", cnt_upto(16'hD000, 16), 1);
        chk("model_db6d", cnt_upto(16'hDB6D, 16), 5);
        chk("model_db6d_abort7", cnt_upto(16'hDB6D, 8), 2);
        chk("model_first_0000", first_at(16'h0000, 16), 32'hFFFF_FFFF);

        repeat (3) @(posedge clk);
        chk("reset_det_rst_n", ia.det_rst_n, 0);
        chk("reset_busy", ia.busy, 0);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;

        // 1: single match
        scan(16'hD000, 0, 0, 0);
        chk("t1_stream", wstream, 16'hD000);
        chk("t1_done_cyc", done_cyc, 18);
        chk("t1_count", ia.match_count, 1);
        chk("t1_fvalid", ia.first_valid, 1);
        chk("t1_fpos", ia.first_pos, 3);
        chk("t1_aborted", ia.aborted, 0);

        // 2: overlapping matches, detector cleared only in cycle 1
        scan(16'hDB6D, 0, 0, 0);
        chk("t2_count", ia.match_count, 5);
        chk("t2_fpos", ia.first_pos, 3);
        chk("t2_rstlow_cnt", rstlow_cnt, 1);
        chk("t2_rstlow_cyc", rstlow_cyc, 1);
        // 5 (narrow counter instance on the same scan)
        chk("t5_count_sat", ib.match_count, 3);

        // 3: no matches
        scan(16'h0000, 0, 0, 0);
        chk("t3_count", ia.match_count, 0);
        chk("t3_fvalid", ia.first_valid, 0);
        chk("t3_fpos", ia.first_pos, 0);
        chk("t3_done_width", done_cnt, 1);

        // 4: abort in SHIFT at idx 7 (cycle 9)
        scan(16'hDB6D, 9, 0, 0);
        chk("t4_done_cyc", done_cyc, 10);
        chk("t4_aborted", ia.aborted, 1);
        chk("t4_count", ia.match_count, 2);
        chk("t4_fpos", ia.first_pos, 3);

        // 5: start while busy is ignored
        scan(16'hDB6D, 0, 6, 0);
        chk("t5_busy_cycles", busy_cnt, 18);
        chk("t5_done_cyc", done_cyc, 18);
        chk("t5_count_b", ib.match_count, 3);
        chk("t5_count_a", ia.match_count, 5);

        // 6: reset at SHIFT idx 5 (cycle 7)
        scan(16'hDB6D, 0, 0, 7);
        chk("t6_no_done", done_cnt, 0);
        chk("t6_count", ia.match_count, 0);
        chk("t6_fvalid", ia.first_valid, 0);
        chk("t6_busy", ia.busy, 0);
        scan(16'hD000, 0, 0, 0);
        chk("t6_rescan_count", ia.match_count, 1);

        // Randomized scans, checked cycle by cycle
        for (int k = 0; k < 60; k++) begin
            logic [W-1:0] w;
            int ac, sc, rc;
            w = W'($urandom);
            if ($urandom_range(0, 1) == 1)
                w = (16'hB6DB << $urandom_range(0, 3)) | (W'($urandom) & 16'h0007);
            ac = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 17) : 0;
            sc = ($urandom_range(0, 2) == 0) ? $urandom_range(1, (ac > 0) ? ac : 18) : 0;
            rc = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 18) : 0;
            scan(w, ac, sc, rc);
        end

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/seq_scan_ctrl.md
Name: seq_scan_ctrl

Overview:
Controller that sequences an external 1-bit Mealy sequence detector (serial input w, detection output z, own active-low reset). It accepts a parallel word with a start/busy/done handshake and clears the detector. It then shifts the word out MSB-first, one bit per clock, samples the detector output every bit, and reports the match count and the index of the first match. It sits between a parallel producer (bench or CPU-side register) and the detector instance.

Parameters:
WIDTH, 16, bits per scanned word (>= 2)
CNT_W, 5, width of match counter; saturates at 2^CNT_W-1
POS_W, 4, width of first-match index; must satisfy 2^POS_W >= WIDTH

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
start  input  1  request scan of data_in; honoured only in IDLE
data_in  input  WIDTH  word to scan, latched on accepted start
abort  input  1  terminate scan early (CLEAR or SHIFT only)
busy  output  1  high in CLEAR, SHIFT, DONE
done  output  1  one-cycle pulse in DONE
aborted  output  1  valid with done: scan ended by abort
match_count  output  CNT_W  number of z=1 samples in last scan
first_valid  output  1  at least one match in last scan
first_pos  output  POS_W  bit index (0 = MSB) of first match
det_w  output  1  serial bit to detector input w
det_rst_n  output  1  active-low reset to detector
det_z  input  1  detector output z (Mealy, combinational on det_w)

Behaviour:
- Reset (async, reset_n=0): state=IDLE, shift reg=0, bit index=0. Outputs: match_count=0, first_valid=0, first_pos=0, aborted=0, busy=0, done=0, det_w=0, det_rst_n=0 (detector held in reset with controller).
- States: IDLE, CLEAR, SHIFT, DONE; all transitions on rising clk.
- IDLE: det_rst_n=1, det_w=0. On start=1: latch data_in; clear match_count, first_valid, first_pos, aborted; set idx=0; go CLEAR.
- CLEAR (exactly 1 cycle): det_rst_n=0, det_w=0. Next SHIFT, or DONE with aborted=1 if abort=1.
- SHIFT (WIDTH cycles, one per bit): det_rst_n=1; det_w = shift_reg[WIDTH-1], decoded from registered state only, no input paths.
- SHIFT sampling: det_z is sampled at the edge ending each SHIFT cycle, i.e. the same cycle det_w is presented, because the detector is Mealy.
- On sampled det_z=1: match_count increments, holding at all-ones if already saturated. If first_valid=0, set first_valid=1 and first_pos=idx.
- Each SHIFT edge: shift left by 1 (LSB fill 0), idx+1. When idx=WIDTH-1, go DONE.
- Abort in SHIFT: the sample of the current cycle is still taken, then go DONE with aborted=1.
- DONE (1 cycle): done=1, busy=1, det_rst_n=1, det_w=0. Next IDLE.
- Result holding: match_count, first_valid, first_pos and aborted hold until the next accepted start.
- Latency: start accepted at edge 0. CLEAR occupies cycle 1, SHIFT cycles 2..WIDTH+1, DONE cycle WIDTH+2. The next start is accepted at edge WIDTH+3 at the earliest.
- Start handling: start while busy=1 is ignored, not queued. start and abort together in IDLE: start wins, and abort is ignored in IDLE.
- Reset mid-scan: everything returns to reset values immediately; no done pulse.

Test Plan:
All cases use WIDTH=16 with a behavioural overlapping 1101 Mealy detector model; the first four use CNT_W=5.
1. data_in=16'hD000, start pulse -> det_w stream 1,1,0,1,0x12; done at cycle 18; match_count=1, first_valid=1, first_pos=3, aborted=0.
2. data_in=16'hDB6D -> matches at indices 3,6,9,12,15; match_count=5, first_pos=3; det_rst_n low exactly in cycle 1.
3. data_in=16'h0000 -> match_count=0, first_valid=0, first_pos=0; done pulse width exactly 1 cycle.
4. Start DB6D, assert abort during SHIFT idx=7 -> done next cycle, aborted=1, match_count=2 (indices 3,6), first_pos=3.
5. CNT_W=2, data_in=16'hDB6D -> match_count saturates at 3; start pulsed during SHIFT is ignored and busy stays high until DONE.
6. reset_n low at SHIFT idx=5, then released -> all outputs at reset values, no done; a following 16'hD000 scan gives match_count=1.
